// File: rtl/ssp_tx_fifo_ctrl.sv
// Pointer, occupancy and flag controller for the 8x16 SSP transmit FIFO.
// The register file is external; this block only steers its write enable and pointers.
module ssp_tx_fifo_ctrl #(
  parameter int unsigned TX_INT_LEVEL = 4
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       TxFWrReq,
  input  logic       TxFPop,
  input  logic       TxFClr,
  input  logic       TxOvfClr,
  input  logic       TxIntrMask,
  output logic       RegFileWrEn,
  output logic [2:0] WrPtr,
  output logic [2:0] RdPtr,
  output logic [3:0] TxFCount,
  output logic       TxFEmpty,
  output logic       TxFNotFull,
  output logic       TxFWrOvf,
  output logic       TxRawIntr,
  output logic       TxIntr
);

  localparam logic [3:0] DEPTH   = 4'd8;
  localparam logic [3:0] INT_LVL = 4'(TX_INT_LEVEL);

  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic       empty_q, empty_d;
  logic       not_full_q, not_full_d;
  logic       ovf_q, ovf_d;
  logic       raw_intr_q, raw_intr_d;

  logic full;
  logic empty;
  logic push_acc;
  logic pop_acc;
  logic ovf_evt;

  // Push/pop are single-cycle requests with no ready handshake: a request is
  // accepted in its own cycle when the registered state allows it, otherwise
  // it is dropped (push while full raises the overflow flag, pop while empty
  // is silently ignored). A flush discards both requests of its cycle.
  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == 4'd0);
  assign push_acc = TxFWrReq & ~full  & ~TxFClr;
  assign pop_acc  = TxFPop   & ~empty & ~TxFClr;
  assign ovf_evt  = TxFWrReq &  full  & ~TxFClr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (TxFClr) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 3'd1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 3'd1;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are computed from the next count so they move with the pointers.
  always_comb begin
    empty_d    = (count_d == 4'd0);
    not_full_d = (count_d != DEPTH);
    raw_intr_d = (count_d <= INT_LVL);
    ovf_d      = ovf_evt | (ovf_q & ~TxOvfClr);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      empty_q    <= 1'b1;
      not_full_q <= 1'b1;
      ovf_q      <= 1'b0;
      raw_intr_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      not_full_q <= not_full_d;
      ovf_q      <= ovf_d;
      raw_intr_q <= raw_intr_d;
    end
  end

  assign RegFileWrEn = push_acc;
  assign WrPtr       = wr_ptr_q;
  assign RdPtr       = rd_ptr_q;
  assign TxFCount    = count_q;
  assign TxFEmpty    = empty_q;
  assign TxFNotFull  = not_full_q;
  assign TxFWrOvf    = ovf_q;
  assign TxRawIntr   = raw_intr_q;
  assign TxIntr      = raw_intr_q & TxIntrMask;

endmodule

// File: tb/tb_ssp_tx_fifo_ctrl.sv
// Bench for ssp_tx_fifo_ctrl: directed scenarios then random traffic against a
// queue-based FIFO model with a bench-side 8x16 register file.
module tb_ssp_tx_fifo_ctrl;

  localparam int LVL = 4;

  logic        PCLK;
  logic        PRESETn;
  logic        TxFWrReq, TxFPop, TxFClr, TxOvfClr, TxIntrMask;
  logic        RegFileWrEn;
  logic [2:0]  WrPtr, RdPtr;
  logic [3:0]  TxFCount;
  logic        TxFEmpty, TxFNotFull, TxFWrOvf, TxRawIntr, TxIntr;

  logic [15:0] wdata;
  logic [15:0] mem [8];

  // reference model state
  logic [15:0] exp_q[$];
  int          m_wr_total;
  int          m_rd_total;
  logic        m_ovf;

  int n_vec;
  int n_err;

  ssp_tx_fifo_ctrl #(.TX_INT_LEVEL(LVL)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .TxFWrReq(TxFWrReq), .TxFPop(TxFPop), .TxFClr(TxFClr),
    .TxOvfClr(TxOvfClr), .TxIntrMask(TxIntrMask),
    .RegFileWrEn(RegFileWrEn), .WrPtr(WrPtr), .RdPtr(RdPtr),
    .TxFCount(TxFCount), .TxFEmpty(TxFEmpty), .TxFNotFull(TxFNotFull),
    .TxFWrOvf(TxFWrOvf), .TxRawIntr(TxRawIntr), .TxIntr(TxIntr)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // bench-side register file, written exactly where the controller points
  always @(posedge PCLK) begin
    if (RegFileWrEn) mem[WrPtr] <= wdata;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr_total = 0;
    m_rd_total = 0;
    m_ovf      = 1'b0;
  endtask

  task automatic check_state(input string pfx);
    int cnt;
    cnt = exp_q.size();
    chk({pfx, "_wrptr"},   16'(WrPtr),      16'(m_wr_total % 8));
    chk({pfx, "_rdptr"},   16'(RdPtr),      16'(m_rd_total % 8));
    chk({pfx, "_count"},   16'(TxFCount),   16'(cnt));
    chk({pfx, "_empty"},   16'(TxFEmpty),   16'(cnt == 0));
    chk({pfx, "_notfull"}, 16'(TxFNotFull), 16'(cnt < 8));
    chk({pfx, "_ovf"},     16'(TxFWrOvf),   16'(m_ovf));
    chk({pfx, "_rawint"},  16'(TxRawIntr),  16'(cnt <= LVL));
    chk({pfx, "_intr"},    16'(TxIntr),     16'((cnt <= LVL) && TxIntrMask));
  endtask

  // driver: one cycle of requests, applied at the falling edge
  task automatic step(input logic wr, input logic pop, input logic clr, input logic oc);
    bit full, push_ok, pop_ok, ovf_ev;
    TxFWrReq = wr;
    TxFPop   = pop;
    TxFClr   = clr;
    TxOvfClr = oc;
    wdata    = 16'($urandom);
    #1;
    full    = (exp_q.size() == 8);
    push_ok = wr && !full && !clr;
    pop_ok  = pop && (exp_q.size() != 0) && !clr;
    ovf_ev  = wr && full && !clr;
    check_state("st");
    chk("wren", 16'(RegFileWrEn), 16'(push_ok));
    if (pop_ok) chk("rdata", mem[RdPtr], exp_q[0]);
    @(posedge PCLK);
    if (clr) begin
      exp_q.delete();
      m_wr_total = 0;
      m_rd_total = 0;
    end else begin
      if (pop_ok) begin
        void'(exp_q.pop_front());
        m_rd_total++;
      end
      if (push_ok) begin
        exp_q.push_back(wdata);
        m_wr_total++;
      end
    end
    m_ovf = ovf_ev ? 1'b1 : (oc ? 1'b0 : m_ovf);
    @(negedge PCLK);
    TxFWrReq = 1'b0;
    TxFPop   = 1'b0;
    TxFClr   = 1'b0;
    TxOvfClr = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    PRESETn    = 1'b0;
    TxFWrReq   = 1'b0;
    TxFPop     = 1'b0;
    TxFClr     = 1'b0;
    TxOvfClr   = 1'b0;
    TxIntrMask = 1'b1;
    wdata      = 16'h0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    model_reset();

    repeat (2) @(negedge PCLK);
    check_state("reset");
    chk("reset_wren", 16'(RegFileWrEn), 16'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // fill: eight back-to-back pushes
    for (int i = 0; i < 8; i++) begin
      chk("fill_wrptr", 16'(WrPtr), 16'(i));
      step(1, 0, 0, 0);
      if (i == 3) chk("fill_raw_hi_at4", 16'(TxRawIntr), 16'h1);
      if (i == 4) chk("fill_raw_lo_at5", 16'(TxRawIntr), 16'h0);
    end
    chk("fill_cnt", 16'(TxFCount), 16'd8);
    chk("fill_notfull", 16'(TxFNotFull), 16'h0);

    // overflow, clear, then clear colliding with a new overflow
    step(1, 0, 0, 0);
    chk("ovf_set", 16'(TxFWrOvf), 16'h1);
    chk("ovf_wrptr", 16'(WrPtr), 16'h0);
    step(0, 0, 0, 1);
    chk("ovf_clr", 16'(TxFWrOvf), 16'h0);
    step(1, 0, 0, 1);
    chk("ovf_set_wins", 16'(TxFWrOvf), 16'h1);

    // push+pop while full: push dropped
    step(1, 1, 0, 0);
    chk("full_pp_cnt", 16'(TxFCount), 16'd7);

    // flush at count 6 with a push in the same cycle
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    chk("flush_cnt", 16'(TxFCount), 16'd0);
    chk("flush_ovf_kept", 16'(TxFWrOvf), 16'h1);
    step(0, 0, 0, 1);

    // wrap and drain: bring RdPtr to 6 with count 4
    repeat (6) step(1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    chk("wrap_rdptr6", 16'(RdPtr), 16'd6);
    repeat (4) step(0, 1, 0, 0);
    chk("drain_rdptr", 16'(RdPtr), 16'd2);
    chk("drain_empty", 16'(TxFEmpty), 16'h1);
    step(0, 1, 0, 0);
    chk("drain_extra_pop", 16'(RdPtr), 16'd2);

    // simultaneous push+pop at count 0 and at count 3
    step(1, 1, 0, 0);
    chk("empty_pp_cnt", 16'(TxFCount), 16'd1);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("mid_pp_cnt", 16'(TxFCount), 16'd3);

    // asynchronous reset mid-traffic at count 5
    repeat (2) step(1, 0, 0, 0);
    TxIntrMask = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    model_reset();
    check_state("midrst");
    @(negedge PCLK);
    PRESETn    = 1'b1;
    TxIntrMask = 1'b1;
    @(negedge PCLK);
    chk("post_rst_wrptr", 16'(WrPtr), 16'h0);
    step(1, 0, 0, 0);

    // random traffic: fill-biased then drain-biased phases
    for (int i = 0; i < 600; i++) begin
      int wr_pct;
      wr_pct = (i < 300) ? 75 : 35;
      if ($urandom_range(0, 19) == 0) TxIntrMask = ~TxIntrMask;
      step($urandom_range(0, 99) < wr_pct,
           $urandom_range(0, 99) < (100 - wr_pct),
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 8);
    end
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_tx_fifo_ctrl.md
# ssp_tx_fifo_ctrl

Pointer and flag controller for the SSP transmit FIFO. It sits between the APB data-register write path and the 8×16 transmit register file. It also serves the transmit serialiser that drains the FIFO. It turns push/pop requests into the register-file write enable, the write pointer and the read pointer. It also maintains the occupancy count, the status flags and the raw/masked transmit interrupt.

## Interface
Parameters:
- TX_INT_LEVEL, default 4: transmit interrupt asserts when occupancy ≤ this value. Legal range is 0–7.

Ports:
- PCLK  in  1  APB clock; all state changes on its rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- TxFWrReq  in  1  push request; one-cycle pulse per APB write to the data register
- TxFPop  in  1  pop request from the serialiser
- TxFClr  in  1  synchronous flush of the FIFO
- TxOvfClr  in  1  clears the sticky TxFWrOvf flag
- TxIntrMask  in  1  1 = transmit interrupt enabled
- RegFileWrEn  out  1  write enable to the register file
- WrPtr  out  3  write location for the register file
- RdPtr  out  3  read location; register-file read data is combinational on this pointer
- TxFCount  out  4  occupancy, 0–8
- TxFEmpty  out  1  occupancy = 0
- TxFNotFull  out  1  occupancy < 8
- TxFWrOvf  out  1  sticky flag: a push was dropped while full
- TxRawIntr  out  1  occupancy ≤ TX_INT_LEVEL
- TxIntr  out  1  TxRawIntr & TxIntrMask

## Operation
- Full is defined as occupancy = 8. Empty is defined as occupancy = 0. Both are evaluated on the registered state at the start of the cycle.
- Push accepted = TxFWrReq & ~full & ~TxFClr.
- RegFileWrEn = push accepted. It is combinational, so the register file captures write data at WrPtr on the same edge.
- Pop accepted = TxFPop & ~empty & ~TxFClr. The consumer samples the read data in the same cycle it asserts TxFPop.
- Pointer update on an accepted push: WrPtr += 1, modulo 8 (7 → 0 wrap).
- Pointer update on an accepted pop: RdPtr += 1, modulo 8 (7 → 0 wrap).
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, with both pointers advancing.
- Push when full is dropped, even if a pop is accepted in the same cycle. No pointer or count change results from the dropped push. TxFWrOvf is set on the next edge.
- Pop when empty is ignored. A simultaneous push is still accepted, giving count 0 → 1.
- TxFClr takes priority over everything:
  - WrPtr, RdPtr and TxFCount are set to 0.
  - The push and pop in that cycle are discarded and RegFileWrEn = 0.
  - TxFWrOvf is not affected.
- TxFWrOvf clearing:
  - TxOvfClr clears the flag.
  - If TxOvfClr coincides with a new overflow event, set wins.
- All flags are registered and derived from the next-state count. Flags therefore change on the same edge as the pointers.
- The count never exceeds 8 and never goes below 0. The invariant (WrPtr − RdPtr) mod 8 = TxFCount mod 8 holds at all times.

## Timing
- Reset values of outputs (also the state immediately after any reset, including a reset asserted mid-operation):
  - RegFileWrEn 0 (given TxFWrReq low)
  - WrPtr 0, RdPtr 0, TxFCount 0
  - TxFEmpty 1, TxFNotFull 1, TxFWrOvf 0
  - TxRawIntr 1, TxIntr = TxIntrMask
- Reset mid-operation discards the contents. The register-file contents themselves are reset separately.
- Push latency:
  - RegFileWrEn is high in the request cycle k.
  - Data is stored at edge k.
  - WrPtr, TxFCount and the flags update at edge k and are visible in cycle k+1.
- Pop latency:
  - Data is valid combinationally in the TxFPop cycle.
  - RdPtr and the flags update at the following edge.
- Back-to-back pushes or pops every cycle are supported with no bubbles.
- TxRawIntr deasserts on the edge where the count goes from TX_INT_LEVEL to TX_INT_LEVEL+1. It reasserts on the edge where the count goes from TX_INT_LEVEL+1 to TX_INT_LEVEL.

## Test plan
- Reset: assert PRESETn low mid-traffic with count 5 → all outputs return to their reset values asynchronously. The first push after release writes location 0.
- Fill: 8 pushes in 8 consecutive cycles → RegFileWrEn high for WrPtr 0…7, TxFCount = 8, TxFNotFull = 0. TxRawIntr falls after the 5th push, with count 5 and default level 4.
- Overflow: a 9th push at count 8 → RegFileWrEn = 0, WrPtr stays 0, TxFWrOvf = 1 next cycle. TxOvfClr then clears it; TxOvfClr plus an overflow in the same cycle leaves it at 1.
- Wrap and drain: start with RdPtr = 6 and count 4. Pop 4 times → RdPtr goes 6, 7, 0, 1, 2, TxFEmpty = 1, TxRawIntr stays 1. A 5th pop leaves RdPtr = 2.
- Simultaneous events:
  - At count 3, push+pop → count stays 3 and both pointers advance by 1.
  - At count 0, push+pop → count 1 and only WrPtr advances.
  - At count 8, push+pop → count 7 and the push is dropped.
- Flush: TxFClr together with TxFWrReq at count 6 → RegFileWrEn = 0. Next cycle the pointers are 0, count 0, TxFEmpty = 1, TxFWrOvf is unchanged.
